// File: rtl/aes_pkg.sv
// Shared types, sizes and GF(2^8) helpers for the AES-256 inverse cipher.
// Purely declarative: no state, no latency.
// No flow control lives here; handshakes are in the top level.
package aes_pkg;

    localparam int aes_rounds_lp          = 14;
    localparam int aes_block_width_lp     = 128;
    localparam int aes_key_chain_width_lp = 1920;

    typedef logic [7:0]                    aes_byte_t;
    typedef logic [31:0]                   aes_word_t;
    typedef logic [aes_block_width_lp-1:0] aes_state_t;

    typedef enum logic [1:0] {
        e_idle,
        e_round,
        e_done
    } aes_fsm_e;

    // Multiply by x (0x02) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (09/0b/0d/0e in practice) as a sum of xtime powers.
    function automatic aes_byte_t gf_mul(input aes_byte_t b, input logic [3:0] k);
        aes_byte_t p;
        aes_byte_t acc;
        p   = b;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box lookup, one byte.
// Purely combinational, zero latency.
// No handshake; the caller owns timing.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  aes_byte_t addr,
    output aes_byte_t data
);

    // Row n holds the inverse substitution for inputs 16n..16n+15, first byte in the MSBs.
    localparam logic [2047:0] inv_tbl_lp = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign data = inv_tbl_lp[2047 - 8*addr -: 8];

endmodule

// File: rtl/aes_decryption.sv
// AES-256 inverse cipher, one round per clock, single block in flight.
// Latency: 14 cycles from accept to v_o; next accept the cycle after yumi.
// Backpressure: ready_o low while busy or holding a result; result held until yumi_i.
module aes_decryption
    import aes_pkg::*;
#(
    parameter int num_rounds_p  = 14,
    parameter int block_width_p = 128
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    v_i,
    output logic                                    ready_o,
    input  logic [block_width_p-1:0]                ciphertext_i,
    input  logic [(num_rounds_p+1)*block_width_p-1:0] key_chain_i,
    output logic                                    v_o,
    output logic [block_width_p-1:0]                plaintext_o,
    input  logic                                    yumi_i
);

    aes_fsm_e                          fsm_q;
    aes_state_t                        state_q;
    logic [aes_key_chain_width_lp-1:0] key_q;
    logic [3:0]                        rnd_q;
    logic                              ready_q;
    logic                              v_q;

    aes_state_t rk [0:aes_rounds_lp];
    aes_state_t shifted;
    aes_state_t subbed;
    aes_state_t added;
    aes_state_t next_state;

    // Row r rotates right by r: new[r][c] = old[r][(c-r) mod 4].
    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
        return o;
    endfunction

    // Each output row uses the 0e,0b,0d,09 coefficient row rotated right by its index.
    function automatic aes_state_t inv_mix_columns(input aes_state_t s);
        aes_state_t o;
        aes_byte_t  a [4];
        aes_byte_t  acc;
        logic [3:0] coef [4];
        coef = '{4'he, 4'hb, 4'hd, 4'h9};
        o    = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 8*(4*c + k) -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(a[k], coef[(k - r + 4) % 4]);
                o[127 - 8*(4*c + r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    // Slice the latched chain into round keys; round key 0 sits in the MSBs.
    for (genvar r = 0; r <= aes_rounds_lp; r++) begin : g_rk
        assign rk[r] = key_q[aes_key_chain_width_lp - 1 - 128*r -: 128];
    end

    assign shifted = inv_shift_rows(state_q);

    // Sixteen parallel inverse S-boxes, one per state byte.
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_inv_sbox u_inv_sbox (
            .addr (shifted[127 - 8*i -: 8]),
            .data (subbed[127 - 8*i -: 8])
        );
    end

    // The final round (rnd 0) has no InvMixColumns.
    assign added      = subbed ^ rk[rnd_q];
    assign next_state = (rnd_q == 4'd0) ? added : inv_mix_columns(added);

    // Control FSM with state, round counter, key latch and registered handshake outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fsm_q   <= e_idle;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= 4'd0;
            ready_q <= 1'b1;
            v_q     <= 1'b0;
        end else begin
            case (fsm_q)
                e_idle: begin
                    if (v_i) begin
                        key_q   <= key_chain_i;
                        state_q <= ciphertext_i ^ key_chain_i[block_width_p-1:0];
                        rnd_q   <= 4'd13;
                        fsm_q   <= e_round;
                        ready_q <= 1'b0;
                    end
                end
                e_round: begin
                    state_q <= next_state;
                    if (rnd_q == 4'd0) begin
                        fsm_q <= e_done;
                        v_q   <= 1'b1;
                    end else begin
                        rnd_q <= rnd_q - 4'd1;
                    end
                end
                e_done: begin
                    if (yumi_i) begin
                        fsm_q   <= e_idle;
                        v_q     <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    fsm_q   <= e_idle;
                    v_q     <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign v_o         = v_q;
    assign plaintext_o = state_q;

endmodule

// File: tb/tb_aes_decryption.sv
// Directed and round-trip checks of the AES-256 inverse cipher.
// Key chains and ciphertexts come from a forward AES-256 model in this file.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
module tb_aes_decryption;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          v_i = 1'b0;
    logic          ready_o;
    logic [127:0]  ciphertext_i = '0;
    logic [1919:0] key_chain_i = '0;
    logic          v_o;
    logic [127:0]  plaintext_o;
    logic          yumi_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    aes_decryption dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .ciphertext_i (ciphertext_i),
        .key_chain_i  (key_chain_i),
        .v_o          (v_o),
        .plaintext_o  (plaintext_o),
        .yumi_i       (yumi_i)
    );

    logic [2047:0] sbox_tbl = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] f_sb(input logic [7:0] b);
        return sbox_tbl[2047 - 8*b -: 8];
    endfunction

    function automatic logic [7:0] f_xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] f_subw(input logic [31:0] w);
        return {f_sb(w[31:24]), f_sb(w[23:16]), f_sb(w[15:8]), f_sb(w[7:0])};
    endfunction

    function automatic logic [1919:0] f_expand(input logic [255:0] key);
        logic [31:0]   w [0:59];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] ch;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = f_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = f_xt(rc);
            end else if (i % 8 == 4) begin
                t = f_subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++)
            ch[1919 - 128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ch;
    endfunction

    function automatic logic [127:0] f_encrypt(input logic [127:0] pt, input logic [1919:0] ch);
        logic [127:0] s;
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ ch[1919 -: 128];
        for (int r = 1; r <= 14; r++) begin
            for (int i = 0; i < 16; i++) s[127 - 8*i -: 8] = f_sb(s[127 - 8*i -: 8]);
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    o[127 - 8*(4*c + q) -: 8] = s[127 - 8*(4*((c + q) % 4) + q) -: 8];
            s = o;
            if (r != 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127 - 32*c -: 8];
                    a1 = s[119 - 32*c -: 8];
                    a2 = s[111 - 32*c -: 8];
                    a3 = s[103 - 32*c -: 8];
                    o[127 - 32*c -: 8] = f_xt(a0) ^ f_xt(a1) ^ a1 ^ a2 ^ a3;
                    o[119 - 32*c -: 8] = a0 ^ f_xt(a1) ^ f_xt(a2) ^ a2 ^ a3;
                    o[111 - 32*c -: 8] = a0 ^ a1 ^ f_xt(a2) ^ f_xt(a3) ^ a3;
                    o[103 - 32*c -: 8] = f_xt(a0) ^ a0 ^ a1 ^ a2 ^ f_xt(a3);
                end
                s = o;
            end
            s = s ^ ch[1919 - 128*r -: 128];
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Present one block for a single accept edge; leaves the bench just after it.
    task automatic accept(input logic [127:0] ct, input logic [1919:0] ch);
        v_i          = 1'b1;
        ciphertext_i = ct;
        key_chain_i  = ch;
        tick();
        v_i = 1'b0;
    endtask

    // Wait (bounded) for v_o, counting edges since the accept edge.
    task automatic wait_result(input int already, output int lat);
        lat = already;
        while (!v_o && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
    endtask

    localparam logic [255:0] key_c3_lp = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] ct_c3_lp  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] pt_c3_lp  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] ct_z_lp   = 128'hdc95c078a2408989ad48a21492842087;

    logic [1919:0] chain_c3;
    logic [1919:0] chain_z;
    logic [1919:0] chain_r;
    logic [255:0]  key_r;
    logic [127:0]  pt_r;
    int            lat;

    initial begin
        // Reset and idle outputs
        tick();
        tick();
        reset_i = 1'b0;
        check("reset_ready", {127'd0, ready_o}, 128'd1);
        check("reset_v", {127'd0, v_o}, 128'd0);
        check("reset_pt", plaintext_o, 128'd0);

        chain_c3 = f_expand(key_c3_lp);
        chain_z  = f_expand(256'd0);
        check("c3_rk14", chain_c3[127:0], 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // FIPS-197 C.3 decrypt with exact latency
        accept(ct_c3_lp, chain_c3);
        check("c3_busy_ready", {127'd0, ready_o}, 128'd0);
        wait_result(0, lat);
        check("c3_latency", 128'(lat), 128'd14);
        check("c3_pt", plaintext_o, pt_c3_lp);

        // Hold the result under back-pressure; inputs wander meanwhile
        ciphertext_i = ct_z_lp;
        key_chain_i  = chain_z;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("bp_v", {127'd0, v_o}, 128'd1);
            check("bp_pt", plaintext_o, pt_c3_lp);
            check("bp_ready", {127'd0, ready_o}, 128'd0);
        end
        consume();
        check("yumi_ready", {127'd0, ready_o}, 128'd1);
        check("yumi_v", {127'd0, v_o}, 128'd0);

        // Back-to-back zero-key block; a busy-time offer of C.3 must be ignored
        accept(ct_z_lp, chain_z);
        check("b2b_accepted", {127'd0, ready_o}, 128'd0);
        ciphertext_i = ct_c3_lp;
        key_chain_i  = chain_c3;
        lat = 0;
        while (!v_o && lat < 40) begin
            tick();
            lat++;
            v_i = (lat >= 3 && lat < 7);
        end
        v_i = 1'b0;
        check("zero_latency", 128'(lat), 128'd14);
        check("zero_pt", plaintext_o, 128'd0);
        consume();
        for (int k = 0; k < 3; k++) begin
            check("ignored_ready", {127'd0, ready_o}, 128'd1);
            check("ignored_v", {127'd0, v_o}, 128'd0);
            tick();
        end

        // Reset during round 5 abandons the block
        accept(ct_c3_lp, chain_c3);
        repeat (5) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("midrst_ready", {127'd0, ready_o}, 128'd1);
        check("midrst_v", {127'd0, v_o}, 128'd0);
        check("midrst_pt", plaintext_o, 128'd0);
        accept(ct_c3_lp, chain_c3);
        wait_result(0, lat);
        check("post_rst_latency", 128'(lat), 128'd14);
        check("post_rst_pt", plaintext_o, pt_c3_lp);
        consume();

        // Random round trips through the forward model
        for (int n = 0; n < 50; n++) begin
            key_r   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt_r    = {$urandom, $urandom, $urandom, $urandom};
            chain_r = f_expand(key_r);
            accept(f_encrypt(pt_r, chain_r), chain_r);
            wait_result(0, lat);
            check("rt_pt", plaintext_o, pt_r);
            consume();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
